// File: rtl/jtframe_sdram_cmdgen_if.sv
// Request/response bus between game logic and the SDRAM command generator.
//   req  : access request, held by the master until ack
//   we   : 1 = write, 0 = read, sampled together with req
//   addr : word address (AW bits)
//   din  : write data
//   ack  : one-cycle pulse, write issued or read data valid
//   dout : read data, valid while ack is high for a read
interface jtframe_sdram_cmdgen_if #(parameter int AW = 22);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   din;
    logic          ack;
    logic [15:0]   dout;

    modport master (output req, we, addr, din, input ack, dout);
    modport slave  (input req, we, addr, din, output ack, dout);
endinterface

// File: rtl/jtframe_sdram_cmdgen.sv
// Single-port SDRAM command generator with closed-row (auto-precharge)
// policy, power-up initialisation and periodic auto-refresh.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : request/ack bus (slave side)
//   init_done    : high once the init sequence has completed
//   sdram_a/ba   : address and bank pins, held through NOP cycles
//   sdram_n*     : command {ncs,nras,ncas,nwe}
//   sdram_dqm    : byte masks, 2'b11 in reset, 0 afterwards
//   dq_out/dq_oe : write data and pad enable
//   dq_in        : read data from the pad
// Every output is registered; the FSM decides in one cycle and the command
// appears on the pins in the next.
module jtframe_sdram_cmdgen #(
    parameter int AW         = 22,
    parameter int TRCD       = 2,
    parameter int CL         = 2,
    parameter int TRP        = 2,
    parameter int TWR        = 2,
    parameter int TRFC       = 7,
    parameter int REF_PERIOD = 780,
    parameter int INIT_WAIT  = 10000
)(
    input  logic                  clk,
    input  logic                  rst,
    jtframe_sdram_cmdgen_if.slave bus,
    output logic                  init_done,
    output logic [12:0]           sdram_a,
    output logic [1:0]            sdram_ba,
    output logic                  sdram_ncs,
    output logic                  sdram_nras,
    output logic                  sdram_ncas,
    output logic                  sdram_nwe,
    output logic [1:0]            sdram_dqm,
    output logic [15:0]           dq_out,
    output logic                  dq_oe,
    input  logic [15:0]           dq_in
);
    // one counter serves every wait, so it must hold the largest of them
    localparam int CW  = $clog2(INIT_WAIT + TRFC + TWR + TRP + TRCD + CL + 2);
    localparam int RCW = $clog2(REF_PERIOD + 1);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam logic [2:0]  CL3      = 3'(CL);
    // burst length 1, sequential, single-write burst
    localparam logic [12:0] MODE_VAL = {3'b000, 1'b1, 2'b00, CL3, 1'b0, 3'b000};

    typedef enum logic [2:0] {
        ST_INIT_WAIT, ST_INIT_PRE, ST_INIT_REF, ST_INIT_MODE,
        ST_IDLE, ST_ACT, ST_RD, ST_WAIT
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [CW-1:0]  wait_last, wait_last_n;   // last count of ST_WAIT
    logic           ref2, ref2_n;             // second init refresh done
    logic [3:0]     cmd, cmd_n;
    logic [12:0]    a_n;
    logic [1:0]     ba_n;
    logic [15:0]    dq_out_n, dout_n;
    logic           dq_oe_n, ack_n, init_done_n;
    logic           we_l, we_n;
    logic [8:0]     col_l, col_n;
    logic [15:0]    din_l, din_n;
    logic           ref_clr;
    logic [RCW-1:0] ref_cnt;
    logic           ref_pend;

    assign {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = cmd;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        wait_last_n = wait_last;
        ref2_n      = ref2;
        cmd_n       = CMD_NOP;
        a_n         = sdram_a;
        ba_n        = sdram_ba;
        dq_out_n    = dq_out;
        dq_oe_n     = 1'b0;
        ack_n       = 1'b0;
        dout_n      = bus.dout;
        init_done_n = init_done;
        we_n        = we_l;
        col_n       = col_l;
        din_n       = din_l;
        ref_clr     = 1'b0;
        case (state)
            ST_INIT_WAIT:
                if (cnt == CW'(INIT_WAIT - 1)) begin
                    cmd_n   = CMD_PRE;
                    a_n     = 13'h0400;     // A10: all banks
                    state_n = ST_INIT_PRE;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            ST_INIT_PRE:
                if (cnt == CW'(TRP)) begin
                    cmd_n   = CMD_REF;
                    ref2_n  = 1'b0;
                    state_n = ST_INIT_REF;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            ST_INIT_REF:
                if (cnt == CW'(TRFC)) begin
                    cnt_n = '0;
                    if (!ref2) begin
                        cmd_n  = CMD_REF;
                        ref2_n = 1'b1;
                    end else begin
                        cmd_n   = CMD_MRS;
                        a_n     = MODE_VAL;
                        ba_n    = 2'b00;
                        state_n = ST_INIT_MODE;
                    end
                end else cnt_n = cnt + 1'b1;
            ST_INIT_MODE:
                if (cnt == CW'(2)) begin
                    init_done_n = 1'b1;
                    state_n     = ST_IDLE;
                end else cnt_n = cnt + 1'b1;
            ST_IDLE:
                if (ref_pend) begin
                    cmd_n       = CMD_REF;
                    ref_clr     = 1'b1;
                    wait_last_n = CW'(TRFC - 1);
                    state_n     = ST_WAIT;
                    cnt_n       = '0;
                end else if (bus.req && init_done) begin
                    cmd_n   = CMD_ACT;
                    ba_n    = bus.addr[AW-1:AW-2];
                    a_n     = 13'(bus.addr[AW-3:9]);
                    we_n    = bus.we;
                    col_n   = bus.addr[8:0];
                    din_n   = bus.din;
                    state_n = ST_ACT;
                    cnt_n   = '0;
                end
            ST_ACT:
                if (cnt == CW'(TRCD - 1)) begin
                    a_n   = {2'b00, 1'b1, 1'b0, col_l};   // A10: auto-precharge
                    cnt_n = '0;
                    if (we_l) begin
                        cmd_n       = CMD_WR;
                        dq_oe_n     = 1'b1;
                        dq_out_n    = din_l;
                        ack_n       = 1'b1;
                        wait_last_n = CW'(TWR + TRP - 1);
                        state_n     = ST_WAIT;
                    end else begin
                        cmd_n   = CMD_RD;
                        state_n = ST_RD;
                    end
                end else cnt_n = cnt + 1'b1;
            ST_RD:
                // data is on dq_in CL cycles after READ; capture and ack together
                if (cnt == CW'(CL)) begin
                    dout_n      = dq_in;
                    ack_n       = 1'b1;
                    wait_last_n = CW'(TRP - 1);
                    state_n     = ST_WAIT;
                    cnt_n       = '0;
                end else cnt_n = cnt + 1'b1;
            ST_WAIT:
                if (cnt == wait_last) state_n = ST_IDLE;
                else cnt_n = cnt + 1'b1;
            default: state_n = ST_INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT_WAIT;
            cnt       <= '0;
            wait_last <= '0;
            ref2      <= 1'b0;
            cmd       <= CMD_NOP;
            sdram_a   <= '0;
            sdram_ba  <= '0;
            sdram_dqm <= 2'b11;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            bus.ack   <= 1'b0;
            bus.dout  <= '0;
            init_done <= 1'b0;
            we_l      <= 1'b0;
            col_l     <= '0;
            din_l     <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            wait_last <= wait_last_n;
            ref2      <= ref2_n;
            cmd       <= cmd_n;
            sdram_a   <= a_n;
            sdram_ba  <= ba_n;
            sdram_dqm <= 2'b00;
            dq_out    <= dq_out_n;
            dq_oe     <= dq_oe_n;
            bus.ack   <= ack_n;
            bus.dout  <= dout_n;
            init_done <= init_done_n;
            we_l      <= we_n;
            col_l     <= col_n;
            din_l     <= din_n;
        end
    end

    // Free-running refresh timer. A wrap while a refresh is still pending
    // is simply absorbed; a wrap coinciding with the clear keeps it pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else if (ref_cnt == RCW'(REF_PERIOD - 1)) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
            if (ref_clr) ref_pend <= 1'b0;
        end
    end
endmodule

// File: doc/jtframe_sdram_cmdgen.md
Name: jtframe_sdram_cmdgen

Overview:
- Single-port SDRAM command generator. It turns word read/write requests from game logic into SDRAM ACTIVE/READ/WRITE/REFRESH/PRECHARGE/LOAD MODE commands.
- It sits directly upstream of the SDRAM pins and of the bank-statistics monitor, which taps the same command/address outputs.
- Row policy is closed-row: every access uses auto-precharge.
- It also runs power-up initialisation and periodic auto-refresh.

Parameters:
- AW, 22, word address width. bank = addr[AW-1:AW-2], row = addr[AW-3:9] (zero-extended to 13 bits), col = addr[8:0].
- TRCD, 2, cycles from ACTIVE to READ/WRITE.
- CL, 2, CAS latency (2 or 3); also written to the mode register.
- TRP, 2, precharge time in cycles.
- TWR, 2, write recovery in cycles.
- TRFC, 7, cycles from REFRESH to the next command.
- REF_PERIOD, 780, cycles between refresh requests.
- INIT_WAIT, 10000, power-up NOP cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  1  access request; held until ack
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  AW  word address
- din  in  16  write data
- ack  out  1  one-cycle pulse: write issued, or read data valid
- dout  out  16  read data, valid when ack=1 for a read
- init_done  out  1  high once initialisation is complete
- sdram_a  out  13  address
- sdram_ba  out  2  bank
- sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe  out  1 each  command {ncs,nras,ncas,nwe}
- sdram_dqm  out  2  byte masks; always 0 after reset
- dq_out  out  16  write data to the pad
- dq_oe  out  1  pad output enable
- dq_in  in  16  read data from the pad

Behaviour:
- All outputs are registered. Cycle numbers below refer to pin-visible cycles.
- Reset values:
  - cmd = NOP (0111); sdram_a = 0; sdram_ba = 0; dqm = 2'b11.
  - dq_oe = 0; ack = 0; dout = 0; init_done = 0.
  - Refresh counter = 0; refresh-pending = 0; FSM = INIT_WAIT.
- Reset asserted mid-operation aborts immediately to these values. The whole init sequence is re-run.
- FSM states and transitions:
  - INIT_WAIT: INIT_WAIT NOP cycles, then INIT_PRE.
  - INIT_PRE: PRECHARGE with A10=1 (all banks), then TRP NOPs, then INIT_REF.
  - INIT_REF: two REFRESH commands, each followed by TRFC NOPs, then INIT_MODE.
  - INIT_MODE: LOAD MODE with sdram_a = {3'b0, 1'b1, 2'b0, CL[2:0], 1'b0, 3'b000} (single-write burst, burst length 1), ba = 0. Then 2 NOPs, init_done <= 1, go to IDLE.
  - IDLE:
    - If refresh is pending: issue REFRESH, clear pending, TRFC NOPs, back to IDLE.
    - Else if req: latch we/addr/din and issue ACTIVE (ba, row) at cycle t. NOPs fill t+1 .. t+TRCD-1. Go to RW.
    - Refresh wins when both are present in IDLE.
  - RW (cycle t+TRCD):
    - Write: WRITE with A10=1, A8:0 = col; dq_oe = 1 and dq_out = din for this cycle only; ack pulses in this same cycle. Then TWR+TRP NOPs, then IDLE.
    - Read: READ with A10=1. dq_in is sampled into dout at cycle t+TRCD+CL, and ack pulses at t+TRCD+CL+1. Then TRP NOPs after the ack cycle, then IDLE.
- Refresh counter:
  - Free-runs from reset and is not gated by init_done.
  - Wraps from REF_PERIOD-1 to 0 and sets pending on the wrap.
  - A second wrap while pending is still set is absorbed: pending stays at 1 and no count is kept.
  - Pending is ignored until the FSM reaches IDLE.
- req and handshake rules:
  - req while init_done = 0 is held off; no ack is given.
  - Requester changes to we/addr/din after the ACTIVE cycle have no effect.
  - The requester deasserts req in the cycle after ack. If req is still high in IDLE, a new access starts.
- During NOP cycles sdram_a and sdram_ba hold their last value.

Test Plan:
- Reset, run INIT_WAIT = 20 -> cycle 20 PRECHARGE with A10 = 1. Then 2 REFRESH spaced 1+TRFC cycles apart. Then LOAD MODE with sdram_a = 13'h220. init_done rises after 2 further NOPs.
- Write addr = 22'h3F_FE05, din = 16'hBEEF -> ACTIVE ba = 3, row = 11'h7FF. Two cycles later WRITE with sdram_a = 13'h0405, dq_oe = 1, dq_out = BEEF, ack in the same cycle. The next command is no earlier than 1+TWR+TRP cycles later.
- Read addr = 0; model drives dq_in = 16'h1234 at ACTIVE+4 -> dout = 1234 and ack = 1 at ACTIVE+5 (CL = 2).
- Hold req high while the refresh counter wraps during a read -> read completes, then REFRESH is issued before the next ACTIVE, then the held req is served.
- REF_PERIOD = 8, FSM kept busy for 20 cycles -> exactly one REFRESH issued on return to IDLE.
- Assert rst during the cycle between READ and ack -> no ack, cmd = NOP, init_done = 0, init sequence restarts from INIT_WAIT.
